int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 148 ++++++++++++++
 tb/tb_int_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects up to eight level sources into a pending
// register, gates them with a mask, and runs a single-level request/service
// handshake with the CPU controller (request -> ack -> service -> eret).
module int_ctrl #(
    parameter int              NSRC     = 4,
    parameter logic [NSRC-1:0] MASK_RST = {NSRC{1'b1}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            clr_we,
    input  logic [NSRC-1:0] clr_wdata,
    input  logic            int_ack,
    input  logic            eret,
    output logic            int_req,
    output logic [2:0]      int_id,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic            in_service,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_id;
    logic [2:0]      w_id_next;
    logic [NSRC-1:0] r_irq_q;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_armed;
    logic [NSRC-1:0] w_id_onehot;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_pending_next;
    logic [2:0]      w_sel;
    logic            w_ack_ok;
    logic            w_eret_ok;

    assign w_rise    = irq_in & ~r_irq_q;
    assign w_armed   = r_pending & r_mask;
    // Handshake pulses only act in the one state where they are legal.
    assign w_ack_ok  = (r_state == ST_REQ) && int_ack;
    assign w_eret_ok = (r_state == ST_SERVICE) && eret;

    // Fixed-priority encoder: the lowest armed index wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        w_sel = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_armed[i]) begin
                w_sel = 3'(i);
            end
        end
    end

    // One-hot of the committed id, used to clear its pending bit on ack.
    always_comb begin
        w_id_onehot = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_id_onehot[i] = (r_id == 3'(i));
        end
    end

    // Clears from software and from ack combine; a same-edge rising edge wins.
    always_comb begin
        w_clr = '0;
        if (clr_we) begin
            w_clr = clr_wdata;
        end
        if (w_ack_ok) begin
            w_clr = w_clr | w_id_onehot;
        end
        w_pending_next = (r_pending & ~w_clr) | w_rise;
    end

    // Edge-detect history, pending and mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_q   <= '0;
            r_pending <= '0;
            r_mask    <= MASK_RST;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_irq_q   <= irq_in;
            r_pending <= w_pending_next;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    // FSM state and committed id registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_id    <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_id    <= w_id_next;
        end
    end

    // Next-state logic; the id is latched only when leaving IDLE so a
    // committed request cannot be disturbed by mask, clear or new edges.
    always_comb begin
        w_state_next = r_state;
        w_id_next    = r_id;
        case (r_state)
            ST_IDLE: begin
                if (|w_armed) begin
                    w_state_next = ST_REQ;
                    w_id_next    = w_sel;
                end
            end
            ST_REQ: begin
                if (w_ack_ok) begin
                    w_state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (w_eret_ok) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are register values or decodes of the state register only.
    assign int_req    = (r_state == ST_REQ);
    assign in_service = (r_state == ST_SERVICE);
    assign int_id     = r_id;
    assign pending    = r_pending;
    assign mask       = r_mask;
    assign state      = r_state;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: walks the request/service handshake, priority,
// masking, committed requests, set-wins cases and asynchronous reset.
module tb_int_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       clr_we;
    logic [3:0] clr_wdata;
    logic       int_ack;
    logic       eret;
    logic       int_req;
    logic [2:0] int_id;
    logic [3:0] pending;
    logic [3:0] mask;
    logic       in_service;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    int_ctrl #(.NSRC(4), .MASK_RST(4'b1111)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .clr_we     (clr_we),
        .clr_wdata  (clr_wdata),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_id     (int_id),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_fsm(input string tag, input logic [1:0] st, input logic req,
                             input logic svc, input logic [2:0] id);
        check({tag, ".state"}, 8'(state), 8'(st));
        check({tag, ".int_req"}, 8'(int_req), 8'(req));
        check({tag, ".in_service"}, 8'(in_service), 8'(svc));
        check({tag, ".int_id"}, 8'(int_id), 8'(id));
    endtask

    initial begin
        reset      = 1'b1;
        irq_in     = 4'b0000;
        mask_we    = 1'b0;
        mask_wdata = 4'b0000;
        clr_we     = 1'b0;
        clr_wdata  = 4'b0000;
        int_ack    = 1'b0;
        eret       = 1'b0;
        tick();
        tick();

        // Reset values
        check_fsm("rst", 2'b00, 1'b0, 1'b0, 3'd0);
        check("rst.pending", 8'(pending), 8'h0);
        check("rst.mask", 8'(mask), 8'hF);
        reset = 1'b0;
        tick();

        // Single source, with stray ack/eret in IDLE ignored
        int_ack = 1'b1;
        eret    = 1'b1;
        tick();
        int_ack = 1'b0;
        eret    = 1'b0;
        check_fsm("idle_ignore", 2'b00, 1'b0, 1'b0, 3'd0);
        irq_in = 4'b0010;
        tick();                                   // E0
        check("single.E0.pending", 8'(pending), 8'h2);
        check_fsm("single.E0", 2'b00, 1'b0, 1'b0, 3'd0);
        irq_in = 4'b0000;
        tick();                                   // E1
        check_fsm("single.E1", 2'b01, 1'b1, 1'b0, 3'd1);
        tick();
        check_fsm("single.hold", 2'b01, 1'b1, 1'b0, 3'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("single.ack.pending", 8'(pending), 8'h0);
        check_fsm("single.ack", 2'b10, 1'b0, 1'b1, 3'd1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check_fsm("single.eret", 2'b00, 1'b0, 1'b0, 3'd1);

        // Priority, ack+eret together in REQ, eret ignored in REQ
        irq_in = 4'b1001;
        tick();
        check("prio.pending", 8'(pending), 8'h9);
        irq_in = 4'b0000;
        tick();
        check_fsm("prio.first", 2'b01, 1'b1, 1'b0, 3'd0);
        int_ack = 1'b1;
        eret    = 1'b1;
        tick();
        int_ack = 1'b0;
        eret    = 1'b0;
        check_fsm("prio.both_in_req", 2'b10, 1'b0, 1'b1, 3'd0);
        check("prio.after_ack0.pending", 8'(pending), 8'h8);
        int_ack = 1'b1;
        eret    = 1'b1;
        tick();
        int_ack = 1'b0;
        eret    = 1'b0;
        check_fsm("prio.both_in_svc", 2'b00, 1'b0, 1'b0, 3'd0);
        check("prio.idle.pending", 8'(pending), 8'h8);
        tick();
        check_fsm("prio.second", 2'b01, 1'b1, 1'b0, 3'd3);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check_fsm("prio.eret_in_req", 2'b01, 1'b1, 1'b0, 3'd3);
        check("prio.second.pending", 8'(pending), 8'h8);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("prio.ack3.pending", 8'(pending), 8'h0);
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // Mask gates arbitration only
        mask_we    = 1'b1;
        mask_wdata = 4'b1101;
        tick();
        mask_we = 1'b0;
        check("mask.write", 8'(mask), 8'hD);
        irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        check("mask.pending", 8'(pending), 8'h2);
        tick();
        tick();
        check_fsm("mask.blocked", 2'b00, 1'b0, 1'b0, 3'd3);
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        check("mask.unmask.edge1", 8'(int_req), 8'h0);
        tick();
        check_fsm("mask.unmask.edge2", 2'b01, 1'b1, 1'b0, 3'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // Committed request survives mask and clear writes
        irq_in = 4'b0100;
        tick();
        irq_in = 4'b0000;
        tick();
        check_fsm("commit.req", 2'b01, 1'b1, 1'b0, 3'd2);
        mask_we    = 1'b1;
        mask_wdata = 4'b0000;
        clr_we     = 1'b1;
        clr_wdata  = 4'b0100;
        tick();
        mask_we = 1'b0;
        clr_we  = 1'b0;
        check("commit.pending", 8'(pending), 8'h0);
        check("commit.mask", 8'(mask), 8'h0);
        check_fsm("commit.hold1", 2'b01, 1'b1, 1'b0, 3'd2);
        tick();
        check_fsm("commit.hold2", 2'b01, 1'b1, 1'b0, 3'd2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_fsm("commit.ack", 2'b10, 1'b0, 1'b1, 3'd2);
        eret       = 1'b1;
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        eret    = 1'b0;
        mask_we = 1'b0;

        // Set wins over clr_we on the same edge
        irq_in    = 4'b0001;
        clr_we    = 1'b1;
        clr_wdata = 4'b0001;
        tick();
        clr_we = 1'b0;
        irq_in = 4'b0000;
        check("setwins.clr.pending", 8'(pending), 8'h1);
        tick();
        check_fsm("setwins.req", 2'b01, 1'b1, 1'b0, 3'd0);
        // Set wins over ack on the same edge
        irq_in  = 4'b0001;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_fsm("setwins.ack", 2'b10, 1'b0, 1'b1, 3'd0);
        check("setwins.ack.pending", 8'(pending), 8'h1);

        // Asynchronous reset mid-SERVICE with irq_in[0] held high
        #2;
        reset = 1'b1;
        #1;
        check_fsm("async.rst", 2'b00, 1'b0, 1'b0, 3'd0);
        check("async.rst.pending", 8'(pending), 8'h0);
        reset = 1'b0;
        tick();
        check("async.release.pending", 8'(pending), 8'h1);
        check("async.release.state", 8'(state), 8'h0);
        tick();
        check_fsm("async.rereq", 2'b01, 1'b1, 1'b0, 3'd0);
        irq_in = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
